// File: rtl/systolic_array_param_pkg.sv
// systolic_array_param_pkg: fixed-point defaults, types and saturation helper for the systolic array.
package systolic_array_param_pkg;
  localparam int FIXED_W = 16;
  localparam int FIXED_FRAC = 8;
  typedef logic signed [FIXED_W-1:0] fixed_t;
  // Clamp a wide signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/systolic_array_param_if.sv
// systolic_array_param_if: host bus of the systolic array (column size, activations, weights, switch, results).
interface systolic_array_param_if import systolic_array_param_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DATA_W = FIXED_W
);
  logic [15:0] ub_rd_col_size_in;
  logic ub_rd_col_size_valid_in;
  logic [ROWS*DATA_W-1:0] sys_data_in;
  logic [ROWS-1:0] sys_valid_in;
  logic [COLS*DATA_W-1:0] sys_weight_in;
  logic [COLS-1:0] sys_accept_w;
  logic sys_switch_in;
  logic [COLS*DATA_W-1:0] sys_data_out;
  logic [COLS-1:0] sys_valid_out;
  modport master (
    output ub_rd_col_size_in, ub_rd_col_size_valid_in, sys_data_in, sys_valid_in,
    output sys_weight_in, sys_accept_w, sys_switch_in,
    input sys_data_out, sys_valid_out
  );
  modport slave (
    input ub_rd_col_size_in, ub_rd_col_size_valid_in, sys_data_in, sys_valid_in,
    input sys_weight_in, sys_accept_w, sys_switch_in,
    output sys_data_out, sys_valid_out
  );
endinterface

// File: rtl/systolic_array_param_pe.sv
// systolic_pe: weight-stationary MAC cell with double-buffered weight; SYSTOLIC_SAT_EN selects saturating math.
module systolic_pe import systolic_array_param_pkg::*; #(
  parameter int DATA_W = FIXED_W,
  parameter int FRAC = FIXED_FRAC
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic signed [DATA_W-1:0] act_in,
  input logic signed [DATA_W-1:0] psum_in,
  input logic signed [DATA_W-1:0] weight_in,
  input logic valid_in,
  input logic accept_w,
  input logic switch_in,
  output logic signed [DATA_W-1:0] act_out,
  output logic signed [DATA_W-1:0] psum_out,
  output logic signed [DATA_W-1:0] weight_out,
  output logic valid_out,
  output logic switch_out
);
  logic signed [DATA_W-1:0] shadow, active, w_eff, prod_t, sum_t;
  assign weight_out = shadow;
  // The swap is visible to the MAC in the very cycle the wavefront arrives.
  assign w_eff = switch_in ? shadow : active;
`ifdef SYSTOLIC_SAT_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod = (act_in * w_eff) >>> FRAC;
  assign prod_t = DATA_W'(sat(64'(prod), DATA_W));
  assign sum_t = DATA_W'(sat(64'(psum_in) + 64'(prod_t), DATA_W));
`else
  logic [DATA_W-1:0] prod_unused;
  assign {prod_unused, prod_t} = (act_in * w_eff) >>> FRAC;
  assign sum_t = psum_in + prod_t;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
      act_out <= '0;
      psum_out <= '0;
      valid_out <= 1'b0;
      switch_out <= 1'b0;
    end else begin
      if (accept_w) shadow <= weight_in;
      if (switch_in) active <= shadow;
      switch_out <= switch_in;
      if (en) begin
        act_out <= act_in;
        valid_out <= valid_in;
        psum_out <= valid_in ? sum_t : '0;
      end
    end
  end
endmodule

// File: rtl/systolic_array_param.sv
// systolic_array_param: ROWS x COLS weight-stationary systolic array with column masking and registered outputs.
// Optional saturating arithmetic via SYSTOLIC_SAT_EN (passed through to every PE).
module systolic_array_param import systolic_array_param_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DATA_W = FIXED_W,
  parameter int FRAC = FIXED_FRAC
) (
  input logic clk,
  input logic rst,
  systolic_array_param_if.slave bus
);
  logic signed [DATA_W-1:0] act [ROWS][COLS+1];
  logic signed [DATA_W-1:0] psum [ROWS+1][COLS];
  logic signed [DATA_W-1:0] wgt [ROWS+1][COLS];
  logic vld [ROWS][COLS+1];
  logic sw [ROWS][COLS];
  logic [15:0] col_size;
  logic [COLS-1:0] en;
  logic [COLS*DATA_W-1:0] data_q;
  logic [COLS-1:0] valid_q;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign psum[0][c] = '0;
    assign wgt[0][c] = bus.sys_weight_in[c*DATA_W +: DATA_W];
    assign en[c] = 16'(c) < col_size;
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    assign act[r][0] = bus.sys_data_in[r*DATA_W +: DATA_W];
    assign vld[r][0] = bus.sys_valid_in[r];
    for (genvar c = 0; c < COLS; c++) begin : g_c
      logic sw_in;
      // Wavefront runs down column 0 and right along every row, reaching PE(r,c) after r+c cycles.
      if (c > 0) begin : g_left
        assign sw_in = sw[r][c-1];
      end else if (r > 0) begin : g_top
        assign sw_in = sw[r-1][0];
      end else begin : g_inj
        assign sw_in = bus.sys_switch_in;
      end
      systolic_pe #(.DATA_W(DATA_W), .FRAC(FRAC)) u_pe (
        .clk(clk),
        .rst(rst),
        .en(en[c]),
        .act_in(act[r][c]),
        .psum_in(psum[r][c]),
        .weight_in(wgt[r][c]),
        .valid_in(vld[r][c]),
        .accept_w(bus.sys_accept_w[c]),
        .switch_in(sw_in),
        .act_out(act[r][c+1]),
        .psum_out(psum[r+1][c]),
        .weight_out(wgt[r+1][c]),
        .valid_out(vld[r][c+1]),
        .switch_out(sw[r][c])
      );
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) col_size <= '0;
    else if (bus.ub_rd_col_size_valid_in)
      col_size <= bus.ub_rd_col_size_in > 16'(COLS) ? 16'(COLS) : bus.ub_rd_col_size_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      valid_q <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        data_q[c*DATA_W +: DATA_W] <= en[c] ? psum[ROWS][c] : '0;
        valid_q[c] <= en[c] && vld[ROWS-1][c+1];
      end
    end
  end
  assign bus.sys_data_out = data_q;
  assign bus.sys_valid_out = valid_q;
endmodule

// File: tb/tb_systolic_array_param.sv
// tb_systolic_array_param: directed checks of the 4x4 systolic array (identity, fixed point, masking, double buffering, overflow, reset).
module tb_systolic_array_param;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [15:0] a_m [8][4];
  logic [15:0] e_m [8][4];
  logic [15:0] w_m [4][4];
  int ns, ld_edge, sw_edge;
  logic vld;
  systolic_array_param_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) bus ();
  systolic_array_param #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .FRAC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Drive row r of sample (e-r) so the host skew matches the array, plus optional weight load and switch.
  task automatic step(input int e);
    for (int r = 0; r < ROWS; r++) begin
      int s;
      s = e - r;
      bus.sys_valid_in[r] = vld && s >= 0 && s < ns;
      bus.sys_data_in[r*DW +: DW] = '0;
      if (s >= 0 && s < ns) bus.sys_data_in[r*DW +: DW] = a_m[s][r];
    end
    bus.sys_accept_w = '0;
    bus.sys_weight_in = '0;
    if (ld_edge >= 0 && e >= ld_edge && e < ld_edge + ROWS) begin
      bus.sys_accept_w = '1;
      for (int c = 0; c < COLS; c++) bus.sys_weight_in[c*DW +: DW] = w_m[ROWS-1-(e-ld_edge)][c];
    end
    bus.sys_switch_in = (e == sw_edge);
    tick();
  endtask
  task automatic load_switch();
    ns = 0;
    ld_edge = 0;
    sw_edge = ROWS;
    for (int e = 0; e < 2*ROWS + COLS; e++) step(e);
    ld_edge = -1;
    sw_edge = -1;
  endtask
  task automatic set_col_size(input logic [15:0] v);
    bus.ub_rd_col_size_in = v;
    bus.ub_rd_col_size_valid_in = 1'b1;
    tick();
    bus.ub_rd_col_size_valid_in = 1'b0;
  endtask
  task automatic set_diag(input logic [15:0] v);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) w_m[r][c] = (r == c) ? v : 16'h0;
  endtask
  task automatic fill_samples(input int n);
    for (int s = 0; s < n; s++) for (int r = 0; r < 4; r++) a_m[s][r] = 16'(((s + r) % 4 + 1) * 256);
  endtask
  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (bus.sys_data_out !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h expected=0", bus.sys_data_out);
    end
    checks++;
    if (bus.sys_valid_out !== '0) begin
      failures++;
      $display("FAIL reset_valid got=%b expected=0", bus.sys_valid_out);
    end
    rst = 1'b1;
    set_col_size(16'd100);
  endtask
  task automatic test_identity();
    set_diag(16'h0100);
    load_switch();
    fill_samples(4);
    for (int s = 0; s < 4; s++) for (int c = 0; c < 4; c++) e_m[s][c] = a_m[s][c];
    ns = 4;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      logic [15:0] ed;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns;
        ed = '0;
        if (ev) ed = e_m[s][c];
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== ed) begin
          failures++;
          $display("FAIL identity e=%0d col=%0d got valid=%b data=%h expected valid=%b data=%h",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev, ed);
        end
      end
    end
  endtask
  task automatic test_col_mask();
    set_col_size(16'd1);
    ns = 4;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      logic [15:0] ed;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns && c < 1;
        ed = '0;
        if (ev) ed = e_m[s][c];
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== ed) begin
          failures++;
          $display("FAIL col_mask e=%0d col=%0d got valid=%b data=%h expected valid=%b data=%h",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev, ed);
        end
      end
    end
    set_col_size(16'd4);
  endtask
  task automatic test_no_valid();
    vld = 1'b0;
    ns = 4;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      step(e);
      checks++;
      if (bus.sys_valid_out !== '0 || bus.sys_data_out !== '0) begin
        failures++;
        $display("FAIL no_valid e=%0d got valid=%b data=%h expected valid=0 data=0",
                 e, bus.sys_valid_out, bus.sys_data_out);
      end
    end
    vld = 1'b1;
  endtask
  task automatic test_double_buffer();
    set_diag(16'h0200);
    fill_samples(7);
    for (int s = 0; s < 7; s++) for (int c = 0; c < 4; c++) e_m[s][c] = (s < 4) ? a_m[s][c] : 16'(a_m[s][c] * 2);
    ns = 7;
    ld_edge = 0;
    sw_edge = 4;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      logic [15:0] ed;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns;
        ed = '0;
        if (ev) ed = e_m[s][c];
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== ed) begin
          failures++;
          $display("FAIL double_buffer e=%0d col=%0d got valid=%b data=%h expected valid=%b data=%h",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev, ed);
        end
      end
    end
    ld_edge = -1;
    sw_edge = -1;
  endtask
  task automatic test_fixed_point();
    set_diag(16'h0000);
    w_m[0][0] = 16'h0100;
    w_m[0][1] = 16'h0459;
    w_m[1][0] = 16'h05C0;
    w_m[1][1] = 16'h0100;
    load_switch();
    a_m[0] = '{16'h01CD, 16'h0200, 16'h0000, 16'h0000};
    a_m[1] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0000};
    e_m[0] = '{16'h0D4D, 16'h09D4, 16'h0000, 16'h0000};
    e_m[1] = '{16'h04C0, 16'hFCA7, 16'h0000, 16'h0000};
    ns = 2;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      logic [15:0] ed;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns;
        ed = '0;
        if (ev) ed = e_m[s][c];
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== ed) begin
          failures++;
          $display("FAIL fixed_point e=%0d col=%0d got valid=%b data=%h expected valid=%b data=%h",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev, ed);
        end
      end
    end
  endtask
  task automatic test_overflow();
    set_diag(16'h0000);
    w_m[0][0] = 16'h0200;
    load_switch();
    a_m[0] = '{16'h7F00, 16'h0000, 16'h0000, 16'h0000};
    a_m[1] = '{16'h8100, 16'h0000, 16'h0000, 16'h0000};
`ifdef SYSTOLIC_SAT_EN
    e_m[0] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    e_m[1] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000};
`else
    e_m[0] = '{16'hFE00, 16'h0000, 16'h0000, 16'h0000};
    e_m[1] = '{16'h0200, 16'h0000, 16'h0000, 16'h0000};
`endif
    ns = 2;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      logic [15:0] ed;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns;
        ed = '0;
        if (ev) ed = e_m[s][c];
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== ed) begin
          failures++;
          $display("FAIL overflow e=%0d col=%0d got valid=%b data=%h expected valid=%b data=%h",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev, ed);
        end
      end
    end
  endtask
  task automatic test_mid_reset();
    set_diag(16'h0100);
    load_switch();
    fill_samples(4);
    ns = 4;
    for (int e = 0; e < 6; e++) step(e);
    checks++;
    if (bus.sys_valid_out[0] !== 1'b1 || bus.sys_data_out[DW-1:0] !== a_m[1][0]) begin
      failures++;
      $display("FAIL mid_reset_pre got valid=%b data=%h expected valid=1 data=%h",
               bus.sys_valid_out[0], bus.sys_data_out[DW-1:0], a_m[1][0]);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.sys_data_out !== '0 || bus.sys_valid_out !== '0) begin
      failures++;
      $display("FAIL mid_reset_async got valid=%b data=%h expected valid=0 data=0",
               bus.sys_valid_out, bus.sys_data_out);
    end
    #1 rst = 1'b1;
    bus.sys_valid_in = '0;
    bus.sys_data_in = '0;
    set_col_size(16'd4);
    for (int s = 0; s < 4; s++) for (int c = 0; c < 4; c++) e_m[s][c] = 16'h0000;
    for (int e = 0; e < ns + ROWS + COLS; e++) begin
      int s;
      logic ev;
      step(e);
      for (int c = 0; c < COLS; c++) begin
        s = e - ROWS - c;
        ev = s >= 0 && s < ns;
        checks++;
        if (bus.sys_valid_out[c] !== ev || bus.sys_data_out[c*DW +: DW] !== 16'h0000) begin
          failures++;
          $display("FAIL post_reset e=%0d col=%0d got valid=%b data=%h expected valid=%b data=0000",
                   e, c, bus.sys_valid_out[c], bus.sys_data_out[c*DW +: DW], ev);
        end
      end
    end
  endtask
  initial begin
    bus.ub_rd_col_size_in = '0;
    bus.ub_rd_col_size_valid_in = 1'b0;
    bus.sys_data_in = '0;
    bus.sys_valid_in = '0;
    bus.sys_weight_in = '0;
    bus.sys_accept_w = '0;
    bus.sys_switch_in = 1'b0;
    ns = 0;
    ld_edge = -1;
    sw_edge = -1;
    vld = 1'b1;
    test_reset();
    test_identity();
    test_col_mask();
    test_no_valid();
    test_double_buffer();
    test_fixed_point();
    test_overflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
